half_adder_unit: RTL and testbench



---
 rtl/ha_pkg.sv | 6 +
 rtl/ha_lane.sv | 10 +
 rtl/half_adder_unit.sv | 58 +++++
 tb/tb_half_adder_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ha_pkg.sv
// ha_pkg: shared defaults and lane vector type for the half adder unit.
package ha_pkg;
    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 8;
    typedef logic [DEFAULT_WIDTH-1:0] lane_t;
endpackage

// File: rtl/ha_lane.sv
// ha_lane: single-bit combinational half adder.
module ha_lane (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;
endmodule

// File: rtl/half_adder_unit.sv
// half_adder_unit: WIDTH-lane half adder with live combinational outputs,
// a valid-qualified registered copy and a saturating carry-event counter.
module half_adder_unit
    import ha_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_count
);
    logic [WIDTH-1:0] sum_d, carry_d;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_lane u_lane (
            .a_i     (a[i]),
            .b_i     (b[i]),
            .sum_o   (sum[i]),
            .carry_o (carry[i])
        );
    end

    // Results hold while idle; only out_valid drops.
    always_comb begin
        sum_d   = in_valid ? sum : sum_q;
        carry_d = in_valid ? carry : carry_q;
        valid_d = in_valid;
        cnt_d   = (in_valid && |carry && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign carry_count = cnt_q;
endmodule

// File: tb/tb_half_adder_unit.sv
// tb_half_adder_unit: directed vectors with a queue scoreboard for the registered path.
module tb_half_adder_unit;
    localparam int W  = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [W-1:0]  s;
        logic [W-1:0]  c;
        logic [CW-1:0] n;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  a = '0, b = '0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  sum, carry, sum_q, carry_q;
    logic          out_valid;
    logic [CW-1:0] carry_count;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   exp_cnt = 0;

    half_adder_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .in_valid    (in_valid),
        .sum         (sum),
        .carry       (carry),
        .sum_q       (sum_q),
        .carry_q     (carry_q),
        .out_valid   (out_valid),
        .carry_count (carry_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic comb(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] es, input logic [W-1:0] ec);
        a = av;
        b = bv;
        #2;
        chk("comb_sum", 32'(sum), 32'(es));
        chk("comb_carry", 32'(carry), 32'(ec));
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] es, input logic [W-1:0] ec);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        if (|ec && exp_cnt < 3) exp_cnt++;
        sb.push_back('{s: es, c: ec, n: CW'(exp_cnt)});
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum_q", 32'(sum_q), 32'(e.s));
                chk("carry_q", 32'(carry_q), 32'(e.c));
                chk("carry_count", 32'(carry_count), 32'(e.n));
            end
        end
    end

    initial begin
        #3;
        chk("rst_sum_q", 32'(sum_q), 32'd0);
        chk("rst_carry_q", 32'(carry_q), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(carry_count), 32'd0);
        comb(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        comb(4'b0000, 4'b1111, 4'b1111, 4'b0000);
        comb(4'b1111, 4'b0000, 4'b1111, 4'b0000);
        comb(4'b1111, 4'b1111, 4'b0000, 4'b1111);
        comb(4'b1100, 4'b1010, 4'b0110, 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        issue(4'b0001, 4'b0001, 4'b0000, 4'b0001);
        issue(4'b1100, 4'b1010, 4'b0110, 4'b1000);
        issue(4'b0101, 4'b1010, 4'b1111, 4'b0000);
        issue(4'b1111, 4'b1111, 4'b0000, 4'b1111);
        issue(4'b0011, 4'b0001, 4'b0010, 4'b0001);
        issue(4'b1111, 4'b0001, 4'b1110, 4'b0001);
        @(negedge clk);
        in_valid = 1'b0;
        a = 4'b1111;
        b = 4'b1111;
        @(posedge clk);
        #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_sum_hold", 32'(sum_q), 32'(4'b1110));
        chk("idle_carry_hold", 32'(carry_q), 32'(4'b0001));
        chk("idle_count_hold", 32'(carry_count), 32'd3);
        drain();
        #1;
        rst = 1'b1;
        #1;
        chk("arst_sum_q", 32'(sum_q), 32'd0);
        chk("arst_carry_q", 32'(carry_q), 32'd0);
        chk("arst_count", 32'(carry_count), 32'd0);
        comb(4'b1010, 4'b0110, 4'b1100, 4'b0010);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        issue(4'b0001, 4'b0001, 4'b0000, 4'b0001);
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        chk("final_count", 32'(carry_count), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
